physics_scheduler: RTL

- Time-multiplexed sequencer for the shared per-sprite gravity datapath.
- Steps `sprite_index` through every sprite, holds each one for a fixed settle window so the multicycle combinational calc can resolve, then pulses a capture into the shadow result buffer.
- At each frame boundary it pulses a commit that copies the shadow buffer into the live location/velocity registers.
- Sits between the host load interface (`data_ready`) and the engine's register file, replacing the free-running counters inside the engine.

---
 rtl/physics_scheduler_if.sv | 53 +++++
 rtl/physics_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/physics_scheduler_if.sv
// -----------------------------------------------------------------------------
// physics_scheduler_if
// Control bundle between the host/engine side and the physics scheduler.
//
//   data_ready    host -> sched  level, host has valid initial state (load)
//   step_hold     host -> sched  level, suppress frame commits (pause)
//   sprite_index  sched -> eng   sprite currently driving the shared calc
//   capture       sched -> eng   1-cycle pulse, calc result -> shadow[index]
//   commit        sched -> eng   1-cycle pulse, shadow -> live registers
//   load          sched -> eng   1-cycle pulse, init values -> live registers
//   busy          sched -> host  high while sprites are being calculated
//   overrun       sched -> host  sticky, a frame ended mid-calculation
//   frame_count   sched -> host  commits since the last load, wraps
//
// master: the host / engine side.  slave: the scheduler.
// -----------------------------------------------------------------------------
interface physics_scheduler_if #(
  parameter int IDX_W = 4
);
  logic             data_ready;
  logic             step_hold;
  logic [IDX_W-1:0] sprite_index;
  logic             capture;
  logic             commit;
  logic             load;
  logic             busy;
  logic             overrun;
  logic [15:0]      frame_count;

  modport master (
    output data_ready,
    output step_hold,
    input  sprite_index,
    input  capture,
    input  commit,
    input  load,
    input  busy,
    input  overrun,
    input  frame_count
  );

  modport slave (
    input  data_ready,
    input  step_hold,
    output sprite_index,
    output capture,
    output commit,
    output load,
    output busy,
    output overrun,
    output frame_count
  );
endinterface

// File: rtl/physics_scheduler.sv
// -----------------------------------------------------------------------------
// physics_scheduler
// Time-multiplexed sequencer for the shared per-sprite gravity datapath.
// Each sprite index is held for SETTLE cycles so the multicycle calc can
// resolve, then a capture pulse writes the result into the shadow buffer.
// At every frame boundary the shadow buffer is committed to the live
// registers, provided all sprites were captured and commits are not held.
//
// Ports:
//   clk_162  system clock
//   rst_l    asynchronous active-low reset
//   bus      physics_scheduler_if.slave (see interface file for signals)
//
// Parameters:
//   SPRITES       sprites serviced per frame
//   SETTLE        cycles each sprite index is held before capture
//   FRAME         cycles per physics frame
//   IDX_W         width of sprite_index
//   CHECK_BUDGET  when set, refuse to elaborate if the per-frame calc work
//                 cannot fit in a frame (clear only for overrun experiments)
//
// States:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for the host to present initial state
//   LOAD    | one cycle, init values -> live registers, counters cleared
//   CALC    | stepping sprite_index, capture at the end of each settle window
//   WAIT    | all sprites captured, waiting for the frame boundary
// -----------------------------------------------------------------------------
module physics_scheduler #(
  parameter int SPRITES      = 9,
  parameter int SETTLE       = 32768,
  parameter int FRAME        = 2700000,
  parameter int IDX_W        = (SPRITES > 1) ? $clog2(SPRITES) : 1,
  parameter bit CHECK_BUDGET = 1'b1
) (
  input logic                clk_162,
  input logic                rst_l,
  physics_scheduler_if.slave bus
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int FRM_W = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [FRM_W-1:0] FRAME_LAST  = FRM_W'(FRAME - 1);
  localparam logic [IDX_W-1:0] SPRITE_LAST = IDX_W'(SPRITES - 1);

  // If the whole sprite sweep does not fit inside a frame, every frame overruns.
  if (CHECK_BUDGET && (SPRITES * SETTLE >= FRAME)) begin : g_budget_check
    $error("physics_scheduler: SPRITES*SETTLE must be less than FRAME");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_WAIT
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [SET_W-1:0]   settle_cnt;
  logic [SET_W-1:0]   settle_nxt;
  logic [FRM_W-1:0]   frame_cnt;
  logic [FRM_W-1:0]   frame_nxt;
  logic [IDX_W-1:0]   sprite_idx;
  logic [IDX_W-1:0]   sprite_idx_nxt;
  logic [15:0]        commit_cnt;
  logic [15:0]        commit_cnt_nxt;
  logic               overrun_flag;
  logic               overrun_nxt;

  logic               load_pulse;
  logic               capture_pulse;
  logic               commit_pulse;
  logic               calc_active;

  logic               frame_end;
  logic               settle_done;
  logic               last_sprite;
  logic [FRM_W-1:0]   frame_adv;
  logic               restart;
  logic               enter_load;

  assign frame_end   = (frame_cnt == FRAME_LAST);
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign last_sprite = (sprite_idx == SPRITE_LAST);
  assign frame_adv   = frame_end ? '0 : frame_cnt + FRM_W'(1);

  always_ff @(posedge clk_162 or negedge rst_l) begin
    if (!rst_l) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_nxt     = settle_cnt;
    frame_nxt      = frame_cnt;
    sprite_idx_nxt = sprite_idx;
    commit_cnt_nxt = commit_cnt;
    overrun_nxt    = overrun_flag;
    load_pulse     = 1'b0;
    capture_pulse  = 1'b0;
    commit_pulse   = 1'b0;
    calc_active    = 1'b0;
    restart        = 1'b0;
    enter_load     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.data_ready) begin
          enter_load = 1'b1;
        end
      end

      ST_LOAD: begin
        // The LOAD cycle is cycle 0 of the first frame, so the frame counter
        // already advances here and the first frame end lands FRAME-1 later.
        load_pulse = 1'b1;
        frame_nxt  = frame_adv;
        state_nxt  = ST_CALC;
      end

      ST_CALC: begin
        calc_active   = 1'b1;
        // A capture on the settle boundary is kept even when a load or a
        // frame end takes over the state transition in the same cycle.
        capture_pulse = settle_done;
        frame_nxt     = frame_adv;
        if (bus.data_ready) begin
          enter_load = 1'b1;
        end else if (frame_end) begin
          overrun_nxt = 1'b1;
          restart     = 1'b1;
        end else if (settle_done) begin
          settle_nxt = '0;
          if (last_sprite) begin
            sprite_idx_nxt = '0;
            state_nxt      = ST_WAIT;
          end else begin
            sprite_idx_nxt = sprite_idx + IDX_W'(1);
          end
        end else begin
          settle_nxt = settle_cnt + SET_W'(1);
        end
      end

      ST_WAIT: begin
        frame_nxt = frame_adv;
        if (bus.data_ready) begin
          enter_load = 1'b1;
        end else if (frame_end) begin
          if (!bus.step_hold) begin
            commit_pulse   = 1'b1;
            commit_cnt_nxt = commit_cnt + 16'd1;
          end
          restart = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (restart) begin
      state_nxt      = ST_CALC;
      sprite_idx_nxt = '0;
      settle_nxt     = '0;
    end

    if (enter_load) begin
      state_nxt      = ST_LOAD;
      frame_nxt      = '0;
      settle_nxt     = '0;
      sprite_idx_nxt = '0;
      commit_cnt_nxt = '0;
      overrun_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk_162 or negedge rst_l) begin
    if (!rst_l) begin
      settle_cnt   <= '0;
      frame_cnt    <= '0;
      sprite_idx   <= '0;
      commit_cnt   <= '0;
      overrun_flag <= 1'b0;
    end else begin
      settle_cnt   <= settle_nxt;
      frame_cnt    <= frame_nxt;
      sprite_idx   <= sprite_idx_nxt;
      commit_cnt   <= commit_cnt_nxt;
      overrun_flag <= overrun_nxt;
    end
  end

  assign bus.sprite_index = sprite_idx;
  assign bus.capture      = capture_pulse;
  assign bus.commit       = commit_pulse;
  assign bus.load         = load_pulse;
  assign bus.busy         = calc_active;
  assign bus.overrun      = overrun_flag;
  assign bus.frame_count  = commit_cnt;

  // Commit only happens in WAIT and capture only in CALC.
  a_capture_commit_exclusive : assert property (
    @(posedge clk_162) disable iff (!rst_l) !(capture_pulse && commit_pulse)
  );

  // LOAD always hands over to CALC, so a held data_ready cannot stretch load.
  a_load_single : assert property (
    @(posedge clk_162) disable iff (!rst_l) load_pulse |=> !load_pulse
  );

  a_index_bound : assert property (
    @(posedge clk_162) disable iff (!rst_l) sprite_idx <= SPRITE_LAST
  );

endmodule
